// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - frame-buffer geometry constants and address type
//
// Shared by the frame-buffer arbiter and its round-robin sub-block.
// The frame buffer holds H_PIXELS x V_PIXELS pixels, stored row-major at
// linear addresses 0 .. FB_DEPTH-1.
package vga_pkg;
    localparam int H_PIXELS = 150;
    localparam int V_PIXELS = 75;
    localparam int FB_DEPTH = H_PIXELS * V_PIXELS;
    localparam int FB_AW    = 14;
    localparam int COL_W    = 8;
    localparam int ROW_W    = 7;

    typedef logic [FB_AW-1:0] fb_addr_t;

    localparam fb_addr_t FB_LAST = fb_addr_t'(FB_DEPTH - 1);
endpackage

// File: rtl/vga_rr_arb2.sv
// rtl/vga_rr_arb2.sv - two-requester round-robin grant with pointer register
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_en         arbitration allowed this cycle (port free of display)
//   i_req[1:0]   per-requester request
//   o_gnt[1:0]   one-hot (or zero) grant, combinational from i_req/i_en/pointer
module vga_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    // Preferred requester; after a grant it points at the one not served.
    logic r_rr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en && !rst) begin
            if (i_req[r_rr]) begin
                o_gnt[r_rr] = 1'b1;
            end else if (i_req[~r_rr]) begin
                o_gnt[~r_rr] = 1'b1;
            end
        end
    end

    // Granting requester 0 moves preference to 1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (|o_gnt) begin
            r_rr <= o_gnt[0];
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer port arbiter: display refresh vs two writers
//
// Optional feature macro: VGA_FB_ARB_STARVE_EN (per-writer starvation flags).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_disp_ena        active-region flag from the timing generator
//   i_col, i_row      current pixel position
//   i_wr_valid[1:0]   writer requests
//   i_wr_addr[1:0]    writer linear pixel addresses
//   i_wr_data[1:0]    writer pixel data
//   o_wr_ready[1:0]   writer accept (combinational)
//   o_mem_*           single-port frame-buffer RAM interface
//   i_mem_rdata       RAM read data, one cycle after the read
//   o_pix_valid       pixel output valid, disp_ena delayed two cycles
//   o_pix_data        pixel output, zero when not valid
//   o_starve[1:0]     sticky starvation flags (zero unless feature enabled)
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_disp_ena,
    input  logic [COL_W-1:0]           i_col,
    input  logic [ROW_W-1:0]           i_row,
    input  logic [1:0]                 i_wr_valid,
    input  logic [1:0][FB_AW-1:0]      i_wr_addr,
    input  logic [1:0][DATA_W-1:0]     i_wr_data,
    output logic [1:0]                 o_wr_ready,
    output logic                       o_mem_en,
    output logic                       o_mem_we,
    output logic [FB_AW-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_wdata,
    input  logic [DATA_W-1:0]          i_mem_rdata,
    output logic                       o_pix_valid,
    output logic [DATA_W-1:0]          o_pix_data,
    output logic [1:0]                 o_starve
);
    // Display address: incremented per active pixel instead of row*H+col;
    // the first pixel of a frame forces 0 so the counter resynchronises.
    fb_addr_t r_disp_cnt;
    logic     w_frame_start;
    fb_addr_t w_disp_addr;
    fb_addr_t w_disp_next;

    assign w_frame_start = i_disp_ena && (i_row == '0) && (i_col == '0);
    assign w_disp_addr   = w_frame_start ? '0 : r_disp_cnt;
    assign w_disp_next   = (w_disp_addr == FB_LAST) ? '0 : w_disp_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_cnt <= '0;
        end else if (i_disp_ena) begin
            r_disp_cnt <= w_disp_next;
        end
    end

    // Writers only see the port while display is idle.
    logic [1:0] w_gnt;

    vga_rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (~i_disp_ena),
        .i_req (i_wr_valid),
        .o_gnt (w_gnt)
    );

    assign o_wr_ready = w_gnt;

    logic     w_sel;
    fb_addr_t w_wr_addr;
    logic     w_in_range;

    assign w_sel      = w_gnt[1];
    assign w_wr_addr  = i_wr_addr[w_sel];
    assign w_in_range = (w_wr_addr < fb_addr_t'(FB_DEPTH));

    // Out-of-range beats are still accepted so the writer never deadlocks,
    // but they never reach the RAM.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (!rst) begin
            if (i_disp_ena) begin
                o_mem_en   = 1'b1;
                o_mem_addr = w_disp_addr;
            end else if ((|w_gnt) && w_in_range) begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = w_wr_addr;
                o_mem_wdata = i_wr_data[w_sel];
            end
        end
    end

    // Stage 1 tracks the read in flight; stage 2 captures the returned pixel.
    logic r_ena_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ena_d1    <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
        end else begin
            r_ena_d1    <= i_disp_ena;
            o_pix_valid <= r_ena_d1;
            o_pix_data  <= r_ena_d1 ? i_mem_rdata : '0;
        end
    end

`ifdef VGA_FB_ARB_STARVE_EN
    logic [1:0][8:0] r_wait;
    logic [1:0]      r_starve;

    // The flag sets on the same edge the counter reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait   <= '0;
            r_starve <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_gnt[i]) begin
                    r_wait[i]   <= '0;
                    r_starve[i] <= 1'b0;
                end else if (i_wr_valid[i]) begin
                    if (r_wait[i] != 9'h1FF) begin
                        r_wait[i] <= r_wait[i] + 9'd1;
                    end
                    if ((int'(r_wait[i]) + 1) >= STARVE_LIMIT) begin
                        r_starve[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_starve = r_starve;
`else
    logic w_unused_starve_cfg;
    assign w_unused_starve_cfg = (STARVE_LIMIT == 0);
    assign o_starve = 2'b00;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             disp_ena = 1'b0;
    logic [7:0]       col = '0;
    logic [6:0]       row = '0;
    logic [1:0]       wr_valid = '0;
    logic [1:0][13:0] wr_addr = '0;
    logic [1:0][7:0]  wr_data = '0;
    logic [1:0]       wr_ready;
    logic             mem_en;
    logic             mem_we;
    logic [13:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata = '0;
    logic             pix_valid;
    logic [7:0]       pix_data;
    logic [1:0]       starve;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_disp_ena  (disp_ena),
        .i_col       (col),
        .i_row       (row),
        .i_wr_valid  (wr_valid),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ready  (wr_ready),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_pix_valid (pix_valid),
        .o_pix_data  (pix_data),
        .o_starve    (starve)
    );

    // RAM content model: pixel at address a reads back as a[7:0] ^ 8'hA5.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] ^ 8'hA5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic de, input int r, input int c, input logic [1:0] v);
        disp_ena = de;
        row      = 7'(r);
        col      = 8'(c);
        wr_valid = v;
        #1;
    endtask

    initial begin
        // Reset state, with a writer requesting during blanking.
        rst = 1'b1;
        drive(1'b0, 0, 0, 2'b11);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_wr_ready", wr_ready, 0);
        tick();
        drive(1'b0, 0, 0, 2'b00);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_starve", starve, 0);
        rst = 1'b0;
        tick();

        // Active-line reads (0,0)..(0,3) then two blanking cycles.
        for (int k = 0; k < 7; k++) begin
            drive(k < 4, 0, k, 2'b00);
            if (k < 4) begin
                chk($sformatf("line_addr%0d", k), mem_addr, k);
                chk($sformatf("line_en%0d", k), mem_en, 1);
                chk($sformatf("line_we%0d", k), mem_we, 0);
            end
            case (k)
                0, 1: chk($sformatf("line_pv%0d", k), pix_valid, 0);
                2: begin chk("line_pv2", pix_valid, 1); chk("line_pd2", pix_data, 8'hA5); end
                3: begin chk("line_pv3", pix_valid, 1); chk("line_pd3", pix_data, 8'hA4); end
                4: begin chk("line_pv4", pix_valid, 1); chk("line_pd4", pix_data, 8'hA7); end
                5: begin chk("line_pv5", pix_valid, 1); chk("line_pd5", pix_data, 8'hA6); end
                default: begin chk("line_pv6", pix_valid, 0); chk("line_pd6", pix_data, 0); end
            endcase
            tick();
        end

        // Round robin with both writers valid in blanking.
        wr_addr[0] = 14'd100; wr_data[0] = 8'h11;
        wr_addr[1] = 14'd200; wr_data[1] = 8'h22;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 0, 0, 2'b11);
            chk($sformatf("rr_ready%0d", k), wr_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_we%0d", k), mem_we, 1);
            chk($sformatf("rr_addr%0d", k), mem_addr, (k % 2 == 0) ? 100 : 200);
            chk($sformatf("rr_data%0d", k), mem_wdata, (k % 2 == 0) ? 8'h11 : 8'h22);
            tick();
        end

        // Writer 1 stalls through an active stretch, then wins at blanking.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2, 10 + k, 2'b10);
            chk($sformatf("stall_ready%0d", k), wr_ready, 0);
            chk($sformatf("stall_we%0d", k), mem_we, 0);
            tick();
        end
        drive(1'b0, 2, 0, 2'b10);
        chk("stall_grant", wr_ready, 2'b10);
        chk("stall_addr", mem_addr, 200);
        tick();

        // Out-of-range write accepted but dropped; last legal address lands.
        wr_addr[0] = 14'd11250;
        drive(1'b0, 0, 0, 2'b01);
        chk("oor_ready", wr_ready, 2'b01);
        chk("oor_mem_en", mem_en, 0);
        tick();
        wr_addr[0] = 14'd11249;
        drive(1'b0, 0, 0, 2'b01);
        chk("last_ready", wr_ready, 2'b01);
        chk("last_mem_en", mem_en, 1);
        chk("last_addr", mem_addr, 11249);
        tick();

        // Starvation: writer 0 stalled four active cycles.
        wr_addr[0] = 14'd50;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5, k + 1, 2'b01);
            chk($sformatf("starve_pre%0d", k), starve, 0);
            tick();
        end
        drive(1'b0, 5, 0, 2'b01);
`ifdef VGA_FB_ARB_STARVE_EN
        chk("starve_set", starve, 2'b01);
`else
        chk("starve_off", starve, 2'b00);
`endif
        chk("starve_grant", wr_ready, 2'b01);
        tick();
        drive(1'b0, 5, 0, 2'b00);
        chk("starve_clear", starve, 0);
        tick();

        // Full frame: last pixel at 11249, wrap to 0, resync at (0,0).
        for (int r = 0; r < 75; r++) begin
            for (int c = 0; c < 150; c++) begin
                drive(1'b1, r, c, 2'b00);
                if (r == 1 && c == 0) chk("frame_row1", mem_addr, 150);
                if (r == 74 && c == 149) chk("frame_last", mem_addr, 11249);
                tick();
            end
        end
        drive(1'b1, 0, 1, 2'b00);
        chk("frame_wrap", mem_addr, 0);
        tick();
        drive(1'b1, 0, 0, 2'b00);
        chk("frame_next00", mem_addr, 0);
        tick();
        drive(1'b1, 0, 1, 2'b00);
        chk("frame_next01", mem_addr, 1);
        tick();

        // Reset mid-line.
        drive(1'b1, 3, 7, 2'b00);
        tick();
        rst = 1'b1;
        drive(1'b1, 3, 8, 2'b11);
        chk("mid_rst_en", mem_en, 0);
        chk("mid_rst_ready", wr_ready, 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 3, 0, 2'b00);
        chk("mid_rst_pv", pix_valid, 0);
        chk("mid_rst_pd", pix_data, 0);
        chk("mid_rst_starve", starve, 0);
        tick();
        drive(1'b1, 3, 9, 2'b00);
        chk("mid_rst_addr0", mem_addr, 0);
        tick();
        drive(1'b1, 3, 10, 2'b00);
        chk("mid_rst_addr1", mem_addr, 1);
        tick();
        drive(1'b0, 3, 0, 2'b11);
        chk("mid_rst_rr", wr_ready, 2'b01);
        tick();
        drive(1'b0, 0, 0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
